// File: rtl/clock_en_gen.sv
// clock_en_gen: multi-channel programmable clock-enable generator with glitch-free shadowed config
module clock_en_gen #(
    parameter  int NUM_CH    = 4,
    parameter  int CNT_W     = 16,
    parameter  int RST_MAX   = 1,
    parameter  int RST_THRES = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_max,
    input  logic [CNT_W-1:0]  cfg_thres,
    output logic [NUM_CH-1:0] clk_en,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);

    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0] max_q, max_d;
    logic [NUM_CH-1:0][CNT_W-1:0] thres_q, thres_d;
    logic [NUM_CH-1:0][CNT_W-1:0] sh_max_q, sh_max_d;
    logic [NUM_CH-1:0][CNT_W-1:0] sh_thres_q, sh_thres_d;
    logic [NUM_CH-1:0]            pend_q, pend_d;
    logic [NUM_CH-1:0]            en_q, en_d;
    logic [NUM_CH-1:0]            tick_q, tick_d;
    logic [NUM_CH-1:0]            wr, wrap, apply;
    logic [31:0]                  ch_idx;

    // Widened channel index so out-of-range selects simply match no channel.
    assign ch_idx = 32'(cfg_ch);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr[g]    = cfg_valid && (ch_idx == 32'(g)) && !pend_q[g];
        assign wrap[g]  = cnt_q[g] >= max_q[g];
        assign apply[g] = pend_q[g] && (wrap[g] || !ch_en[g] || sync);
    end

    // Ready unless the addressed channel still holds an unapplied shadow; unknown channels always accept.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_idx == 32'(i)) cfg_ready = !pend_q[i];
    end

    // Per-channel next state: counter, boundary-only config apply, shadow capture, registered outputs.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]      = (!ch_en[i] || wrap[i] || sync) ? '0 : cnt_q[i] + CNT_W'(1);
            max_d[i]      = apply[i] ? sh_max_q[i] : max_q[i];
            thres_d[i]    = apply[i] ? sh_thres_q[i] : thres_q[i];
            sh_max_d[i]   = wr[i] ? cfg_max : sh_max_q[i];
            sh_thres_d[i] = wr[i] ? cfg_thres : sh_thres_q[i];
            pend_d[i]     = apply[i] ? 1'b0 : (wr[i] ? 1'b1 : pend_q[i]);
            en_d[i]       = ch_en[i] && (cnt_q[i] < thres_q[i]);
            tick_d[i]     = ch_en[i] && (cnt_q[i] == '0);
        end
    end

    // State registers with synchronous reset to the default divide-by-two pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            max_q      <= {NUM_CH{CNT_W'(RST_MAX)}};
            thres_q    <= {NUM_CH{CNT_W'(RST_THRES)}};
            sh_max_q   <= '0;
            sh_thres_q <= '0;
            pend_q     <= '0;
            en_q       <= '0;
            tick_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            max_q      <= max_d;
            thres_q    <= thres_d;
            sh_max_q   <= sh_max_d;
            sh_thres_q <= sh_thres_d;
            pend_q     <= pend_d;
            en_q       <= en_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_en  = en_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_clock_en_gen.sv
// tb_clock_en_gen: randomized and directed checks of clock_en_gen against a cycle-level reference model
module tb_clock_en_gen;

    localparam int NCH = 4;
    localparam int W   = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           sync = 1'b0;
    logic           cfg_valid = 1'b0;
    logic [NCH-1:0] ch_en = '0;
    logic [1:0]     cfg_ch = '0;
    logic [W-1:0]   cfg_max = '0;
    logic [W-1:0]   cfg_thres = '0;
    logic           cfg_ready;
    logic [NCH-1:0] clk_en, tick, pending;

    logic           cfg_valid3 = 1'b0;
    logic [2:0]     ch_en3 = 3'b111;
    logic [1:0]     cfg_ch3 = '0;
    logic           cfg_ready3;
    logic [2:0]     clk_en3, tick3, pending3;

    int tests = 0;
    int fails = 0;

    int pos[NCH], mx[NCH], thr[NCH], shm[NCH], sht[NCH];
    bit pend[NCH];
    bit primed = 1'b0;
    logic [NCH-1:0] e_en, e_tick, e_pend;

    clock_en_gen #(.NUM_CH(NCH), .CNT_W(W), .RST_MAX(1), .RST_THRES(1)) u_dut (
        .clk(clk), .rst(rst), .ch_en(ch_en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_max(cfg_max), .cfg_thres(cfg_thres),
        .clk_en(clk_en), .tick(tick), .pending(pending)
    );

    clock_en_gen #(.NUM_CH(3), .CNT_W(W), .RST_MAX(1), .RST_THRES(1)) u_dut3 (
        .clk(clk), .rst(rst), .ch_en(ch_en3), .sync(sync),
        .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3), .cfg_ch(cfg_ch3),
        .cfg_max(cfg_max), .cfg_thres(cfg_thres),
        .clk_en(clk_en3), .tick(tick3), .pending(pending3)
    );

    always #5 clk = ~clk;

    // Model: each channel tracks its position within the period; outputs follow the position seen at the edge.
    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            bit acc;
            bit bnd;
            if (rst) begin
                pos[i] = 0; mx[i] = 1; thr[i] = 1; shm[i] = 0; sht[i] = 0; pend[i] = 0;
                e_en[i] = 0; e_tick[i] = 0; e_pend[i] = 0;
            end else begin
                acc = cfg_valid && (int'(cfg_ch) == i) && !pend[i];
                e_en[i] = ch_en[i] && (pos[i] < thr[i]);
                e_tick[i] = ch_en[i] && (pos[i] == 0);
                bnd = !ch_en[i] || (pos[i] >= mx[i]) || sync;
                if (pend[i] && bnd) begin
                    mx[i] = shm[i]; thr[i] = sht[i]; pend[i] = 0;
                end
                pos[i] = bnd ? 0 : pos[i] + 1;
                if (acc) begin
                    shm[i] = int'(cfg_max); sht[i] = int'(cfg_thres); pend[i] = 1;
                end
                e_pend[i] = pend[i];
            end
        end
        primed = 1'b1;
    endtask

    task automatic cycle();
        logic exp_rdy;
        @(negedge clk);
        if (primed) begin
            exp_rdy = !pend[cfg_ch];
            tests++;
            if (cfg_ready !== exp_rdy) begin
                fails++;
                $display("FAIL cfg_ready ch=%0d got %b exp %b at %0t", cfg_ch, cfg_ready, exp_rdy, $time);
            end
        end
        @(posedge clk);
        model_step();
        #1;
        tests++;
        if (clk_en !== e_en) begin
            fails++;
            $display("FAIL clk_en got %b exp %b at %0t", clk_en, e_en, $time);
        end
        tests++;
        if (tick !== e_tick) begin
            fails++;
            $display("FAIL tick got %b exp %b at %0t", tick, e_tick, $time);
        end
        tests++;
        if (pending !== e_pend) begin
            fails++;
            $display("FAIL pending got %b exp %b at %0t", pending, e_pend, $time);
        end
    endtask

    task automatic write(input logic [1:0] ch, input int m, input int t);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_max = W'(m); cfg_thres = W'(t);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ch_en = '0;
        repeat (2) cycle();
        tests++;
        if ({clk_en, tick, pending} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %b/%b/%b exp 0/0/0", clk_en, tick, pending);
        end
        rst = 1'b0; ch_en = '1;
        cycle();
        tests++;
        if (clk_en !== 4'hF) begin
            fails++;
            $display("FAIL default_first_high got %b exp 1111", clk_en);
        end
        repeat (9) cycle();
    endtask

    task automatic test_cfg_write();
        write(2'd1, 4, 2);
        tests++;
        if (pending !== 4'b0010) begin
            fails++;
            $display("FAIL write_pending got %b exp 0010", pending);
        end
        for (int k = 0; k < 14; k++) begin
            cfg_ch = 2'(k % 2);
            cycle();
        end
    endtask

    task automatic test_thres_edges();
        write(2'd2, 3, 0);
        repeat (12) cycle();
        tests++;
        if (clk_en[2] !== 1'b0) begin
            fails++;
            $display("FAIL thres_zero got %b exp 0", clk_en[2]);
        end
        write(2'd2, 3, 7);
        repeat (12) cycle();
        tests++;
        if (clk_en[2] !== 1'b1) begin
            fails++;
            $display("FAIL thres_over got %b exp 1", clk_en[2]);
        end
    endtask

    task automatic test_sync();
        write(2'd0, 9, 5);
        write(2'd3, 6, 3);
        repeat (13) cycle();
        sync = 1'b1;
        cycle();
        sync = 1'b0;
        cycle();
        tests++;
        if (tick !== 4'hF) begin
            fails++;
            $display("FAIL sync_realign got %b exp 1111", tick);
        end
        repeat (10) cycle();
    endtask

    task automatic test_disable();
        write(2'd1, 2, 1);
        ch_en[1] = 1'b0;
        cycle();
        tests++;
        if (clk_en[1] !== 1'b0 || pending[1] !== 1'b0) begin
            fails++;
            $display("FAIL disable_apply got en=%b pend=%b exp en=0 pend=0", clk_en[1], pending[1]);
        end
        repeat (2) cycle();
        ch_en[1] = 1'b1;
        cycle();
        tests++;
        if (tick[1] !== 1'b1 || clk_en[1] !== 1'b1) begin
            fails++;
            $display("FAIL reenable got tick=%b en=%b exp 1/1", tick[1], clk_en[1]);
        end
        repeat (8) cycle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
            sync = ($urandom_range(0, 31) == 0);
            rst = ($urandom_range(0, 99) == 0);
            cfg_valid = ($urandom_range(0, 2) == 0);
            cfg_ch = 2'($urandom_range(0, 3));
            cfg_max = W'($urandom_range(0, 6));
            cfg_thres = W'($urandom_range(0, 8));
            cycle();
        end
        rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0; ch_en = '1;
        repeat (4) cycle();
    endtask

    task automatic test_reset_mid();
        write(2'd0, 5, 3);
        write(2'd2, 7, 2);
        rst = 1'b1;
        cycle();
        tests++;
        if ({clk_en, tick, pending} !== '0) begin
            fails++;
            $display("FAIL reset_mid got %b/%b/%b exp 0/0/0", clk_en, tick, pending);
        end
        rst = 1'b0;
        repeat (6) cycle();
    endtask

    task automatic test_out_of_range();
        logic [2:0] prev;
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_max = W'(5); cfg_thres = W'(2);
        @(negedge clk);
        tests++;
        if (cfg_ready3 !== 1'b1) begin
            fails++;
            $display("FAIL oor_ready got %b exp 1", cfg_ready3);
        end
        @(negedge clk);
        cfg_valid3 = 1'b0;
        prev = clk_en3;
        repeat (3) @(negedge clk);
        tests++;
        if (pending3 !== 3'b000 || clk_en3 !== tick3 || (clk_en3 ^ prev) !== 3'b111) begin
            fails++;
            $display("FAIL oor_nochange got pend=%b en=%b tick=%b prev=%b exp pend=000 en=tick toggling", pending3, clk_en3, tick3, prev);
        end
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd0;
        @(negedge clk);
        cfg_valid3 = 1'b0;
        tests++;
        if (pending3 !== 3'b001) begin
            fails++;
            $display("FAIL inrange_write got %b exp 001", pending3);
        end
    endtask

    initial begin
        test_reset();
        test_cfg_write();
        test_thres_edges();
        test_sync();
        test_disable();
        test_random();
        test_reset_mid();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
